// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder_if
// Description : Display-drive inputs and decoded-frame outputs of the
//               7-segment scan decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_decoder_if #(
  parameter int N_DIGITS = 4
);
  logic [N_DIGITS-1:0]   an_n;
  logic [6:0]            seg_n;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   err;
  logic                  frame_valid;

  modport master (
    output an_n, seg_n,
    input  value, err, frame_valid
  );

  modport slave (
    input  an_n, seg_n,
    output value, err, frame_valid
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Recovers hex digits from a multiplexed active-low 7-segment
//               drive and publishes one N-digit word per completed scan.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_decoder #(
  parameter int N_DIGITS = 4,
  parameter int SETTLE   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int c_cnt_w = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int c_idx_w = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_COUNT = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  // Bit 4 of the result marks an illegal glyph; the nibble is then 0.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0011000: return 5'h09;
      7'b0001000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
      default:    return 5'h10;
    endcase
  endfunction

  logic [N_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
  logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  state_t                r_state, w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [N_DIGITS-1:0]   r_seen;
  logic [4*N_DIGITS-1:0] r_shadow, r_value;
  logic [N_DIGITS-1:0]   r_shadow_err, r_err;
  logic                  r_frame_valid;

  logic [N_DIGITS-1:0]   w_sel;
  logic                  w_valid, w_change, w_capture, w_seen_full;
  logic [c_idx_w-1:0]    w_idx;
  logic [4:0]            w_dec;

  // Synchronisers idle at all-ones so reset looks like a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
    end else begin
      r_an_s1    <= bus.an_n;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= bus.seg_n;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  assign w_sel       = ~r_an_s2;
  assign w_valid     = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_change    = (r_an_s2 != r_an_prev) || (r_seg_s2 != r_seg_prev);
  assign w_dec       = f_decode(r_seg_s2);
  assign w_seen_full = &r_seen;
  assign w_cnt_inc   = r_cnt + 1'b1;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_sel[i]) w_idx = c_idx_w'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = '0;
        if (w_valid && !w_change) begin
          if (SETTLE == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HELD;
          end else begin
            w_cnt_nxt   = c_cnt_w'(1);
            w_state_nxt = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (w_change || !w_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_cnt_w'(SETTLE)) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HELD;
          end
        end
      end
      S_HELD: begin
        if (w_change || !w_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Publish clears seen first; a same-edge capture then re-sets its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen        <= '0;
      r_shadow      <= '0;
      r_shadow_err  <= '0;
      r_value       <= '0;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_seen_full;
      if (w_seen_full) begin
        r_value <= r_shadow;
        r_err   <= r_shadow_err;
        r_seen  <= '0;
      end
      if (w_capture) begin
        r_shadow[4*w_idx +: 4] <= w_dec[3:0];
        r_shadow_err[w_idx]    <= w_dec[4];
        r_seen[w_idx]          <= 1'b1;
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.err         = r_err;
  assign bus.frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Directed scans with a frame scoreboard for seg7_scan_decoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [19:0] exp_q[$];
  logic [6:0]  glyph[16];

  localparam logic [6:0] c_blank = 7'b1111111;
  localparam logic [6:0] c_seven = 7'b1111000;

  seg7_scan_decoder_if #(.N_DIGITS(4)) dif ();

  seg7_scan_decoder #(.N_DIGITS(4), .SETTLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every frame_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && dif.frame_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got value=%h err=%b expected no frame",
                 dif.value, dif.err);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("frame_value", 32'(dif.value), 32'(e[19:4]));
        chk("frame_err",   32'(dif.err),   32'(e[3:0]));
      end
    end
  end

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    @(negedge clk);
    dif.an_n  = an;
    dif.seg_n = seg;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input int d1len);
    dwell(4'b1110, s0, 10);
    dwell(4'b1101, s1, d1len);
    dwell(4'b1011, s2, 10);
    dwell(4'b0111, s3, 10);
    dwell(4'b1111, c_blank, 5);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst_n     = 1'b0;
    dif.an_n  = 4'b1111;
    dif.seg_n = c_blank;
    repeat (3) @(negedge clk);
    chk("reset_value", 32'(dif.value), 32'h0);
    chk("reset_err",   32'(dif.err),   32'h0);
    chk("reset_fv",    32'(dif.frame_valid), 32'h0);
    rst_n = 1'b1;

    // 1: plain in-order scan
    exp_q.push_back({16'h4321, 4'b0000});
    scan(glyph[1], glyph[2], glyph[3], glyph[4], 10);

    // 2: blank glyph on digit 2
    exp_q.push_back({16'h4021, 4'b0100});
    scan(glyph[1], glyph[2], c_blank, glyph[4], 10);

    // 3: digit 1 too short, then completed by a proper dwell
    scan(glyph[1], glyph[2], glyph[3], glyph[4], 3);
    chk("short_dwell_queue", 32'(exp_q.size()), 32'd0);
    exp_q.push_back({16'h4321, 4'b0000});
    dwell(4'b1101, glyph[2], 10);
    dwell(4'b1111, c_blank, 5);

    // 4: invalid selects hold outputs
    dwell(4'b1100, glyph[5], 20);
    dwell(4'b1111, glyph[5], 20);
    dwell(4'b1111, c_blank, 5);
    chk("invalid_sel_value", 32'(dif.value), 32'h4321);
    chk("invalid_sel_err",   32'(dif.err),   32'h0);

    // 5: reset mid-frame
    dwell(4'b1110, glyph[9], 10);
    dwell(4'b1101, glyph[8], 10);
    dwell(4'b1011, glyph[7], 10);
    pulse_reset();
    chk("midreset_value", 32'(dif.value), 32'h0);
    chk("midreset_err",   32'(dif.err),   32'h0);
    chk("midreset_fv",    32'(dif.frame_valid), 32'h0);
    dwell(4'b0111, glyph[6], 10);
    dwell(4'b1111, c_blank, 10);
    chk("after_reset_value", 32'(dif.value), 32'h0);

    // 6: sweep digit 0 through every glyph
    pulse_reset();
    for (int g = 0; g < 16; g++) begin
      exp_q.push_back({12'h777, 4'(g), 4'b0000});
      scan(glyph[g], c_seven, c_seven, c_seven, 10);
    end

    repeat (10) @(negedge clk);
    chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
